// File: rtl/spi_defs.sv
// Shared SPI definitions: FSM state encoding and default frame parameters.
// Used by both the SPI master and spi_slave_sync.
package spi_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

    localparam int         SPI_DATA_W    = 8;
    localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_slave_sync_if.sv
// Host-side parallel byte ports of spi_slave_sync (TX and RX valid/ready handshakes).
interface spi_slave_sync_if
    import spi_defs::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;

    modport master (output tx_data, tx_valid, rx_ack,
                    input  tx_ready, rx_data, rx_valid);

    modport slave  (input  tx_data, tx_valid, rx_ack,
                    output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with one-cycle rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!rst) sr <= {3{RST_VAL}};
        else      sr <= {sr[1:0], din};
    end

    assign dout = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder oversampled in the clk domain, with host byte handshakes.
// Optional sticky overrun flag built when SPI_SLAVE_OVERRUN_EN is defined.
//
// state  | meaning
// IDLE   | waiting for ss falling edge; miso driven 0
// SHIFT  | frame active; sample mosi on sck rise, shift miso on sck fall
// DONE   | one cycle; publish received byte to rx_data/rx_valid
module spi_slave_sync
    import spi_defs::*;
#(
    parameter int              DATA_W    = SPI_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(SPI_IDLE_BYTE)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic miso,
    output logic busy,
    output logic overrun,
    spi_slave_sync_if.slave host
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              sck_s, sck_rise, sck_fall;
    logic              ss_s, ss_rise, ss_fall;
    logic [1:0]        mosi_q;
    spi_state_e        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift, rx_shift, tx_hold, start_byte;
    logic              tx_full, start, done;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(sck), .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    // ss idles high, so its synchronizer resets high to avoid a false fall.
    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(ss), .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst) mosi_q <= '0;
        else      mosi_q <= {mosi_q[0], mosi};
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (ss_fall) state_nxt = ST_SHIFT;
                ST_SHIFT: begin
                    if (ss_rise)
                        state_nxt = ST_IDLE;
                    else if (sck_rise && bit_cnt == CNT_W'(DATA_W - 1))
                        state_nxt = ST_DONE;
                end
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    assign start         = (state == ST_IDLE) && (state_nxt == ST_SHIFT);
    assign done          = (state == ST_DONE) && en;
    assign start_byte    = tx_full ? tx_hold : IDLE_BYTE;
    assign busy          = (state != ST_IDLE);
    assign host.tx_ready = ~tx_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_hold       <= '0;
            tx_full       <= 1'b0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            miso          <= 1'b0;
            host.rx_data  <= '0;
            host.rx_valid <= 1'b0;
        end else begin
            // A start in the same cycle as an offer uses the old holding content.
            if (host.tx_valid && !tx_full) begin
                tx_hold <= host.tx_data;
                tx_full <= 1'b1;
            end else if (start) begin
                tx_full <= 1'b0;
            end

            if (start) begin
                tx_shift <= start_byte;
                miso     <= start_byte[DATA_W-1];
                rx_shift <= '0;
                bit_cnt  <= '0;
            end else if (state == ST_SHIFT && state_nxt != ST_IDLE) begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[DATA_W-2:0], mosi_q[1]};
                    bit_cnt  <= bit_cnt + 1'b1;
                end
                if (sck_fall) begin
                    tx_shift <= tx_shift << 1;
                    miso     <= tx_shift[DATA_W-2];
                end
            end

            if (state_nxt == ST_IDLE)
                miso <= 1'b0;

            if (done) begin
                host.rx_data  <= rx_shift;
                host.rx_valid <= 1'b1;
            end else if (host.rx_ack) begin
                host.rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (!rst)                                     overrun <= 1'b0;
        else if (done && host.rx_valid && !host.rx_ack) overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = sck_s ^ ss_s;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Self-checking bench for spi_slave_sync: table vectors, random frames against a
// frame-level reference model, and hand sequences for abort/ack/overrun corners.
module tb_spi_slave_sync;
    import spi_defs::*;

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic sck = 1'b0, ss = 1'b1, mosi = 1'b0;
    logic miso, busy, overrun;

    spi_slave_sync_if #(.DATA_W(8)) host();

    spi_slave_sync #(.DATA_W(8), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .rst(rst), .en(en), .sck(sck), .ss(ss), .mosi(mosi),
        .miso(miso), .busy(busy), .overrun(overrun), .host(host)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level model: one-deep TX holding slot, last RX byte, sticky overrun.
    logic [7:0] m_tx_q[$];
    logic       m_rx_valid = 1'b0;
    logic [7:0] m_rx_data  = 8'h00;
    logic       m_overrun  = 1'b0;

    typedef struct {
        bit         load;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        host.tx_data  = b;
        host.tx_valid = 1'b1;
        tick(1);
        host.tx_valid = 1'b0;
        if (m_tx_q.size() == 0) m_tx_q.push_back(b);
        chk("tx_ready_after_load", 8'(host.tx_ready), 8'd0);
    endtask

    task automatic ack_rx();
        host.rx_ack = 1'b1;
        tick(1);
        host.rx_ack = 1'b0;
        m_rx_valid  = 1'b0;
    endtask

    // Master at clk/8: 4 clk low, 4 clk high per bit; miso sampled at each sck rise.
    task automatic spi_frame(input logic [7:0] mo, input int nbits, input bit ack_done,
                             output logic [7:0] mi, output logic busy_end);
        mi   = 8'h00;
        mosi = mo[7];
        ss   = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            mi[7-i] = miso;
            sck = 1'b1;
            if (ack_done && i == nbits - 1) begin
                tick(3);
                host.rx_ack = 1'b1;
                tick(1);
                host.rx_ack = 1'b0;
            end else begin
                tick(4);
            end
            sck = 1'b0;
            if (i < 7) mosi = mo[6-i];
            tick(4);
        end
        ss = 1'b1;
        tick(3);
        busy_end = busy;
        tick(1);
    endtask

    // Runs one frame, updates the model and compares every observable output.
    task automatic model_frame(input string tag, input logic [7:0] mo, input int nbits,
                               input bit ack_done);
        logic [7:0] mi, exp_mi, mask;
        logic       b_end;
        exp_mi = (m_tx_q.size() != 0) ? m_tx_q.pop_front() : 8'hFF;
        spi_frame(mo, nbits, ack_done, mi, b_end);
        if (nbits == 8) begin
            if (m_rx_valid && !ack_done && OVR_EN) m_overrun = 1'b1;
            m_rx_valid = 1'b1;
            m_rx_data  = mo;
        end
        mask = 8'hFF << (8 - nbits);
        chk({tag, "_miso"},     mi & mask, exp_mi & mask);
        chk({tag, "_rx_data"},  host.rx_data, m_rx_data);
        chk({tag, "_rx_valid"}, 8'(host.rx_valid), 8'(m_rx_valid));
        chk({tag, "_busy_end"}, 8'(b_end), 8'd0);
        chk({tag, "_tx_ready"}, 8'(host.tx_ready), 8'd1);
        chk({tag, "_overrun"},  8'(overrun), 8'(m_overrun));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] mi;
        logic       b_end;
        host.tx_data = 8'h00; host.tx_valid = 1'b0; host.rx_ack = 1'b0;

        // Reset held while pins toggle.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sck = ~sck; ss = ~ss; mosi = ~mosi;
            tick(1);
        end
        chk("rst_miso",     8'(miso), 8'd0);
        chk("rst_rx_data",  host.rx_data, 8'h00);
        chk("rst_rx_valid", 8'(host.rx_valid), 8'd0);
        chk("rst_tx_ready", 8'(host.tx_ready), 8'd1);
        chk("rst_busy",     8'(busy), 8'd0);
        chk("rst_overrun",  8'(overrun), 8'd0);
        sck = 1'b0; ss = 1'b1; mosi = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);

        // ss fall to busy/miso: 3 cycles; zero-bit abort.
        ss = 1'b0;
        tick(2);
        chk("lat_busy_early", 8'(busy), 8'd0);
        tick(1);
        chk("lat_busy",  8'(busy), 8'd1);
        chk("lat_miso",  8'(miso), 8'd1);
        ss = 1'b1;
        tick(3);
        chk("lat_abort_busy", 8'(busy), 8'd0);
        tick(2);

        vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vt[1] = '{1'b0, 8'h00, 8'hC3, 8'hFF, 8'hC3};
        vt[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vt[3] = '{1'b1, 8'h81, 8'h01, 8'h81, 8'h01};
        for (int i = 0; i < 4; i++) begin
            ack_rx();
            if (vt[i].load) load_tx(vt[i].tx);
            m_tx_q.delete();
            spi_frame(vt[i].mo, 8, 1'b0, mi, b_end);
            m_rx_valid = 1'b1; m_rx_data = vt[i].mo;
            chk($sformatf("vec%0d_miso", i),     mi, vt[i].exp_mi);
            chk($sformatf("vec%0d_rx_data", i),  host.rx_data, vt[i].exp_rx);
            chk($sformatf("vec%0d_rx_valid", i), 8'(host.rx_valid), 8'd1);
            chk($sformatf("vec%0d_tx_ready", i), 8'(host.tx_ready), 8'd1);
            chk($sformatf("vec%0d_overrun", i),  8'(overrun), 8'd0);
        end

        for (int i = 0; i < 6; i++) begin
            ack_rx();
            if ($urandom_range(1, 0) == 1) load_tx(8'($urandom));
            model_frame($sformatf("rnd%0d", i), 8'($urandom), 8, 1'b0);
        end

        // Abort after 4 bits consumes the TX byte and delivers nothing.
        ack_rx();
        load_tx(8'h96);
        model_frame("abort", 8'h5A, 4, 1'b0);
        model_frame("post_abort", 8'h69, 8, 1'b0);

        // rx_ack in the DONE cycle: set wins, no overrun.
        model_frame("pre_sim", 8'h77, 8, 1'b0);
        model_frame("sim_ack", 8'hE1, 8, 1'b1);
        ack_rx();
        chk("sim_ack_cleared", 8'(host.rx_valid), 8'd0);

        // Two unacknowledged frames.
        model_frame("ovr_first", 8'h11, 8, 1'b0);
        model_frame("ovr_second", 8'h22, 8, 1'b0);
        chk("ovr_final_data", host.rx_data, 8'h22);
        chk("ovr_final_flag", 8'(overrun), 8'(OVR_EN));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

SPI responder (mode 0, MSB first) that runs entirely in the system `clk` domain: it oversamples the external `sck`, `ss` and `mosi` lines, drives `miso`, and exchanges bytes with the host logic through valid/ready-style parallel ports. It is the receiving and responding end of the SPI link driven by the team's SPI master. It sits behind the slave-select decoder, and one `ss` line from the decoder drives it.

## Interface
- `DATA_W`, 8: frame length in bits.
- `IDLE_BYTE`, 8'hFF: byte shifted out when no TX byte is loaded at frame start.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  block enable; low forces IDLE and aborts any frame.
- `sck`  in  1  SPI clock (asynchronous to `clk`); frequency ≤ clk/8.
- `ss`  in  1  slave select, active low (asynchronous).
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master; 0 when not selected.
- `tx_data`  in  DATA_W  byte to send in the next frame.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  TX holding register empty.
- `rx_data`  out  DATA_W  last complete received byte.
- `rx_valid`  out  1  `rx_data` unread; held until acknowledged.
- `rx_ack`  in  1  host consumes `rx_data`.
- `busy`  out  1  frame in progress.
- `overrun`  out  1  sticky: frame completed while `rx_valid` was still set.

## Operation
- `sck` and `ss` each pass through a 2-flop synchronizer and an edge detector. `mosi` passes through 2 flops aligned with `sck`.
- States:
  - IDLE: `ss` falling edge detected with `en` high → SHIFT. The shift register loads the holding register, or `IDLE_BYTE` if the holding register is empty. The holding register empties. `miso` = shift MSB. Bit counter = 0.
  - SHIFT: on a detected `sck` rising edge, the block samples `mosi` into the RX shift register and increments the bit counter. On a detected `sck` falling edge, the TX shift register shifts left and `miso` takes the new MSB. When the counter reaches DATA_W on a rising edge → DONE.
  - DONE (1 cycle): `rx_data` ← RX shift register, `rx_valid` ← 1 → IDLE. The block does not re-arm until `ss` rises and falls again.
- `ss` rising or `en` low while in SHIFT: abort to IDLE. No `rx_valid`. Partial RX bits are discarded. The consumed TX byte is lost.
- TX handshake: when `tx_valid & tx_ready`, the holding register loads `tx_data` and `tx_ready` drops the next cycle. When a frame start and `tx_valid` fall in the same cycle, the frame uses the old content. The new byte is accepted only if `tx_ready` was high that cycle.
- RX handshake: `rx_ack` clears `rx_valid`. When DONE and `rx_ack` fall in the same cycle, set wins: `rx_valid` stays 1 with the new data, and this is not an overrun.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `miso` 0, `rx_data` 0, `rx_valid` 0, `tx_ready` 1, `busy` 0, `overrun` 0, state IDLE, all shift registers and counter 0.
- `ss` falling pin to `busy`/`miso` valid: 3 `clk` cycles (2 sync + 1 register).
- 8th `sck` rising pin to `rx_valid` high: 4 `clk` cycles.
- `sck` falling pin to new `miso` bit: 3 `clk` cycles. This is within half an `sck` period at clk/8.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined: when DONE occurs while `rx_valid` = 1 and `rx_ack` = 0, `overrun` is set sticky and `rx_data` is overwritten. Only reset clears `overrun`.
- `SPI_SLAVE_OVERRUN_EN` undefined: no overrun logic is built, `overrun` is tied to 0, and `rx_data` is silently overwritten.

## Structure
- Shared package `spi_defs`: state encodings (IDLE, SHIFT, DONE), the default `DATA_W`, and the default `IDLE_BYTE`. The SPI master uses the same package.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall pulse outputs. It is instantiated for `sck` and for `ss`.

## Test plan
- Reset: hold `rst`=0 for 4 cycles while toggling `sck`/`ss` → all outputs at reset values, `tx_ready`=1.
- Full-duplex frame: load `tx_data`=8'hA5, master sends 8'h3C at clk/8 → `miso` bits 1,0,1,0,0,1,0,1; `rx_data`=8'h3C; `rx_valid`=1; `tx_ready`=1 after frame start.
- Underrun: frame with no TX byte loaded → `miso` shifts 8'hFF; `rx_data` correct.
- Abort: raise `ss` after 4 bits → `busy` drops within 3 cycles, `rx_valid` stays 0, next full frame receives correctly.
- Overrun (macro on): two frames 8'h11 then 8'h22 without `rx_ack` → `rx_data`=8'h22, `overrun`=1. Macro off → `overrun`=0.
- Simultaneous: `rx_ack` asserted in the DONE cycle → `rx_valid` remains 1 with new byte, `overrun`=0.
